// File: rtl/crc3_pkg.sv
// crc3_pkg: shared CRC-3 constants and checker FSM state type
package crc3_pkg;
  localparam int MSG_BITS = 5;
  localparam int CRC_W = 3;
  localparam int FRAME_BITS = MSG_BITS + CRC_W;
  localparam logic [CRC_W:0] POLY = 4'b1011;
  typedef enum logic [1:0] {IDLE, RECV, DONE} state_t;
endpackage

// File: rtl/crc3_lfsr.sv
// crc3_lfsr: serial CRC division register shared by encoder and checker
module crc3_lfsr #(
  parameter int W = 3,
  parameter logic [W-1:0] TAPS = 3'b011
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         shift,
  input  logic         clr,
  input  logic         start,
  input  logic         bit_in,
  output logic [W-1:0] syn,
  output logic [W-1:0] syn_next
);
  logic [W-1:0] base;
  // start discards the old remainder so the first bit of a frame enters a zero register
  always_comb begin
    base = start ? '0 : syn;
    syn_next = {base[W-2:0], bit_in} ^ (base[W-1] ? TAPS : '0);
  end
  // remainder register
  always_ff @(posedge clk)
    if (!rst_n || clr) syn <= '0;
    else if (shift) syn <= syn_next;
endmodule

// File: rtl/tt_um_crc3_check.sv
// tt_um_crc3_check: serial CRC-3 codeword checker with saturating error-frame count
module tt_um_crc3_check #(
  parameter int MSG_BITS = crc3_pkg::MSG_BITS,
  parameter int CRC_W = crc3_pkg::CRC_W,
  parameter logic [CRC_W:0] POLY = crc3_pkg::POLY
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);
  import crc3_pkg::*;
  localparam int FRAME = MSG_BITS + CRC_W;
  localparam int CW = $clog2(FRAME);
  state_t state, state_nxt;
  logic [CW-1:0] cnt;
  logic [MSG_BITS-1:0] msg;
  logic [CRC_W-1:0] syn, syn_next;
  logic [4:0] ecnt;
  logic done, ok, err, sample, clr, start, last, unused_ok;
  assign sample = ena && ui_in[0] && !ui_in[2];
  assign clr = ena && ui_in[2];
  assign start = cnt == '0;
  assign last = cnt == CW'(FRAME - 1);
  assign unused_ok = &{1'b0, uio_in, ui_in[7:3]};
  crc3_lfsr #(.W(CRC_W), .TAPS(POLY[CRC_W-1:0])) u_lfsr (
    .clk(clk), .rst_n(rst_n), .shift(sample), .clr(clr), .start(start),
    .bit_in(ui_in[1]), .syn(syn), .syn_next(syn_next)
  );
  // frame state register
  always_ff @(posedge clk)
    state <= !rst_n ? IDLE : state_nxt;
  // frame sequencing: clear wins, otherwise only sampled bits move the frame
  always_comb begin
    state_nxt = state;
    if (clr) state_nxt = IDLE;
    else if (sample) state_nxt = (state == RECV && last) ? DONE : RECV;
  end
  // bit counter, message capture, result flags and error count
  always_ff @(posedge clk)
    if (!rst_n) begin
      cnt <= '0;
      msg <= '0;
      {done, ok, err} <= '0;
      ecnt <= '0;
    end else if (clr) begin
      cnt <= '0;
      msg <= '0;
      {done, ok, err} <= '0;
    end else if (sample) begin
      cnt <= last ? '0 : cnt + 1'b1;
      if (cnt < CW'(MSG_BITS)) msg <= {(start ? {(MSG_BITS-1){1'b0}} : msg[MSG_BITS-2:0]), ui_in[1]};
      done <= last;
      ok <= last && syn_next == '0;
      err <= last && syn_next != '0;
      if (last && syn_next != '0 && !err && ecnt != 5'd31) ecnt <= ecnt + 1'b1;
    end
  assign uo_out = {err, ok, done, msg};
  assign uio_out = {ecnt, syn};
  assign uio_oe = 8'hFF;
endmodule

// File: tb/tb_tt_um_crc3_check.sv
// tb_tt_um_crc3_check: randomized self-checking bench against a polynomial-division model
module tb_tt_um_crc3_check;
  logic clk = 0, rst_n = 0, ena = 1;
  logic [7:0] ui_in = 0, uio_in = 0;
  logic [7:0] uo_out, uio_out, uio_oe;
  int checks = 0, errors = 0;
  int m_ecnt = 0;
  tt_um_crc3_check dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uo_out(uo_out),
    .uio_in(uio_in), .uio_out(uio_out), .uio_oe(uio_oe)
  );
  always #5 clk = ~clk;
  // codeword polynomial modulo x^3+x+1
  function automatic logic [2:0] rem(input logic [7:0] cw);
    int r = cw;
    for (int i = 7; i >= 3; i--) if (r[i]) r = r ^ (11 << (i - 3));
    return r[2:0];
  endfunction
  function automatic logic [7:0] exp_uo(input logic [7:0] cw);
    return {rem(cw) != 0, rem(cw) == 0, 1'b1, cw[7:3]};
  endfunction
  task automatic send_frame(input logic [7:0] cw, input int gap, input bit ena_stretch);
    for (int i = 7; i >= 0; i--) begin
      if (ena_stretch && i == 3) begin
        ena = 0;
        ui_in = {5'b0, 1'b0, ~cw[i], 1'b1};
        repeat (4) @(negedge clk);
        ena = 1;
      end
      ui_in = {5'b0, 1'b0, cw[i], 1'b1};
      @(negedge clk);
      ui_in = 0;
      if (i == 7) begin
        checks++;
        if (uo_out[7:5] !== 3'b000 || uo_out[0] !== cw[7]) begin
          errors++;
          $display("FAIL bit1 flags: got uo_out=%h, need flags 0 and msg lsb %b", uo_out, cw[7]);
        end
      end
      if (i != 0) repeat (gap) @(negedge clk);
    end
    if (rem(cw) != 0 && m_ecnt < 31) m_ecnt++;
  endtask
  task automatic check_result(input string name, input logic [7:0] cw);
    checks++;
    if (uo_out !== exp_uo(cw) || uio_out !== {5'(m_ecnt), rem(cw)}) begin
      errors++;
      $display("FAIL %s cw=%h: got uo=%h uio=%h, need uo=%h uio=%h", name, cw, uo_out, uio_out, exp_uo(cw), {5'(m_ecnt), rem(cw)});
    end
  endtask
  task automatic do_reset;
    rst_n = 0;
    ui_in = 8'h07;
    repeat (2) @(negedge clk);
    rst_n = 1;
    ui_in = 0;
    m_ecnt = 0;
  endtask
  task automatic test_reset;
    do_reset();
    checks++;
    if (uo_out !== 8'h00 || uio_out !== 8'h00 || uio_oe !== 8'hFF) begin
      errors++;
      $display("FAIL reset: got uo=%h uio=%h oe=%h, need 00 00 ff", uo_out, uio_out, uio_oe);
    end
  endtask
  task automatic test_good;
    send_frame(8'hAD, 0, 0);
    check_result("good", 8'hAD);
    checks++;
    if (uo_out !== 8'h75) begin
      errors++;
      $display("FAIL good literal: got uo=%h, need 75", uo_out);
    end
    repeat (3) @(negedge clk);
    check_result("hold", 8'hAD);
  endtask
  task automatic test_bad;
    send_frame(8'hAC, 0, 0);
    check_result("last_flip", 8'hAC);
    checks++;
    if (uo_out !== 8'hB5 || uio_out !== 8'h09) begin
      errors++;
      $display("FAIL last_flip literal: got uo=%h uio=%h, need b5 09", uo_out, uio_out);
    end
    send_frame(8'hBD, 0, 0);
    check_result("bit4_flip", 8'hBD);
    checks++;
    if (uo_out !== 8'hB7 || uio_out[2:0] !== 3'b110) begin
      errors++;
      $display("FAIL bit4_flip literal: got uo=%h syn=%b, need b7 110", uo_out, uio_out[2:0]);
    end
  endtask
  task automatic test_gaps;
    send_frame(8'hAD, 3, 1);
    check_result("gaps", 8'hAD);
  endtask
  task automatic test_clear;
    send_frame(8'hAC, 0, 0);
    for (int i = 0; i < 4; i++) begin
      ui_in = {6'b0, 1'(i), 1'b1};
      @(negedge clk);
    end
    ui_in = 8'h07;
    @(negedge clk);
    ui_in = 0;
    checks++;
    if (uo_out !== 8'h00 || uio_out !== {5'(m_ecnt), 3'b000}) begin
      errors++;
      $display("FAIL clear: got uo=%h uio=%h, need 00 %h", uo_out, uio_out, {5'(m_ecnt), 3'b000});
    end
    send_frame(8'hAD, 0, 0);
    check_result("after_clear", 8'hAD);
  endtask
  task automatic test_reset_mid;
    for (int i = 0; i < 4; i++) begin
      ui_in = 8'h03;
      @(negedge clk);
    end
    do_reset();
    send_frame(8'hAD, 0, 0);
    check_result("after_reset", 8'hAD);
  endtask
  task automatic test_random;
    for (int n = 0; n < 20; n++) begin
      logic [7:0] cw = 8'($urandom);
      if (n % 3 == 0) cw = {cw[7:3], rem({cw[7:3], 3'b000})};
      send_frame(cw, $urandom_range(0, 2), n % 5 == 0);
      check_result("random", cw);
    end
  endtask
  task automatic test_back_to_back;
    do_reset();
    for (int n = 0; n < 33; n++) send_frame(8'hAC, 0, 0);
    check_result("b2b", 8'hAC);
    checks++;
    if (uio_out[7:3] !== 5'd31) begin
      errors++;
      $display("FAIL b2b saturate: got count=%0d, need 31", uio_out[7:3]);
    end
  endtask
  initial begin
    test_reset();
    test_good();
    test_bad();
    test_gaps();
    test_clear();
    test_reset_mid();
    test_random();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
